// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and a per-register busy scoreboard.
// Define REGFILE_MP_RDREG_EN to register rd_data/rd_busy (1-cycle read latency).
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*$clog2(NUM_REGS)-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_WR-1:0]          wr_release,
  input  logic                       iss_en,
  input  logic [$clog2(NUM_REGS)-1:0] iss_addr,
  input  logic                       flush,
  output logic [NUM_REGS-1:0]        busy_vec
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0]        mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic [NUM_WR-1:0]        wr_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  // Writes to a hardwired zero register are dropped at the port.
  always_comb begin
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && wr_release[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
    end
    // A new producer supersedes any same-cycle release of the old one.
    if (iss_en) busy_d[iss_addr] = 1'b1;
    if (flush) busy_d = '0;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Later ports are assigned last, so the highest-index port wins a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      logic [AW-1:0]     a;
      logic [DATA_W-1:0] v;
      logic              rel;
      a   = rd_addr[i*AW +: AW];
      v   = mem_q[a];
      rel = 1'b0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == a)) begin
          v   = wr_data[j*DATA_W +: DATA_W];
          rel = rel | wr_release[j];
        end
      end
      if ((ZERO_REG != 0) && (a == '0)) v = '0;
      rd_data_c[i*DATA_W +: DATA_W] = v;
      rd_busy_c[i] = busy_q[a] && !(rel && !(iss_en && (iss_addr == a)));
    end
  end

`ifdef REGFILE_MP_RDREG_EN
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [NUM_RD-1:0]        rd_busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_c;
      rd_busy_q <= rd_busy_c;
    end
  end

  assign rd_data = rst_n ? rd_data_q : '0;
  assign rd_busy = rst_n ? rd_busy_q : '0;
`else
  assign rd_data = rst_n ? rd_data_c : '0;
  assign rd_busy = rst_n ? rd_busy_c : '0;
`endif

  assign busy_vec = rst_n ? busy_q : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default combinational-read build), NUM_WR = 2.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned RD = 2;
  localparam int unsigned WR = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [RD*AW-1:0] rd_addr;
  logic [RD*DW-1:0] rd_data;
  logic [RD-1:0]    rd_busy;
  logic [WR-1:0]    wr_en;
  logic [WR*AW-1:0] wr_addr;
  logic [WR*DW-1:0] wr_data;
  logic [WR-1:0]    wr_release;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             flush;
  logic [NR-1:0]    busy_vec;

  regfile_mp #(
    .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD), .NUM_WR(WR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_release(wr_release),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 0;

  logic [DW-1:0] m_mem  [NR];
  bit            m_busy [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit released(input int a);
    for (int j = 0; j < WR; j++)
      if (wr_en[j] && wr_release[j] && int'(wr_addr[j*AW +: AW]) == a) return 1;
    return 0;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int i);
    int a = int'(rd_addr[i*AW +: AW]);
    logic [DW-1:0] v;
    if (!rst_n || a == 0) return '0;
    v = m_mem[a];
    for (int j = 0; j < WR; j++)
      if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*DW +: DW];
    return v;
  endfunction

  function automatic bit exp_busy(input int i);
    int a = int'(rd_addr[i*AW +: AW]);
    if (!rst_n) return 0;
    if (released(a) && !(iss_en && int'(iss_addr) == a)) return 0;
    return m_busy[a];
  endfunction

  function automatic logic [NR-1:0] exp_vec();
    logic [NR-1:0] v = '0;
    if (!rst_n) return '0;
    for (int r = 0; r < NR; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // Reference model: storage and scoreboard advance on each rising edge.
  always @(posedge clk) begin
    bit nb [NR];
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) begin
        m_mem[r]  = '0;
        m_busy[r] = 0;
      end
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (flush) nb[r] = 0;
        else if (iss_en && int'(iss_addr) == r) nb[r] = 1;
        else if (released(r)) nb[r] = 0;
        else nb[r] = m_busy[r];
        if (r == 0) nb[r] = 0;
      end
      for (int j = 0; j < WR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0) m_mem[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
      for (int r = 0; r < NR; r++) m_busy[r] = nb[r];
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < RD; i++) begin
        chk($sformatf("rd_data[%0d]", i), 64'(rd_data[i*DW +: DW]), 64'(exp_data(i)));
        chk($sformatf("rd_busy[%0d]", i), 64'(rd_busy[i]), 64'(exp_busy(i)));
      end
      chk("busy_vec", 64'(busy_vec), 64'(exp_vec()));
    end
  end

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_release = '0;
    iss_en = 0; iss_addr = '0; flush = 0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] d, input bit rel);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
    wr_release[p] = rel;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rand_inputs();
    idle();
    rd_addr = RD*AW'($urandom);
    for (int j = 0; j < WR; j++) begin
      int a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, NR - 1);
      if ($urandom_range(0, 1) == 1) set_wr(j, a, $urandom, $urandom_range(0, 1) == 1);
    end
    if ($urandom_range(0, 1) == 1) set_rd(0, int'(wr_addr[AW-1:0]));
    iss_en   = ($urandom_range(0, 3) == 0);
    iss_addr = ($urandom_range(0, 1) == 1) ? wr_addr[AW-1:0] : AW'($urandom);
    flush    = ($urandom_range(0, 15) == 0);
    rst_n    = ($urandom_range(0, 63) != 0);
  endtask

  initial begin
    rst_n = 0;
    rd_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    checking = 1;

    // 1. reset after random traffic
    for (int k = 0; k < 12; k++) begin
      rand_inputs();
      rst_n = 1;
      @(posedge clk);
      #1;
    end
    idle();
    rst_n = 0;
    set_rd(0, 5); set_rd(1, 9);
    @(negedge clk);
    chk("reset rd_data", 64'(rd_data), 64'h0);
    chk("reset busy_vec", 64'(busy_vec), 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    for (int r = 1; r < NR; r++) begin
      set_rd(0, r); set_rd(1, NR - r);
      @(negedge clk);
      chk("post-reset read", 64'(rd_data), 64'h0);
      next();
    end

    // 2. write with same-cycle bypass
    set_wr(0, 5, 32'hDEADBEEF, 0);
    set_rd(0, 5);
    @(negedge clk);
    chk("bypass x5", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
    next();
    set_rd(0, 5);
    @(negedge clk);
    chk("stored x5", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
    next();

    // 3. zero register
    set_wr(0, 0, 32'h1234, 0);
    iss_en = 1; iss_addr = 0;
    set_rd(0, 0);
    @(negedge clk);
    chk("x0 bypass", 64'(rd_data[DW-1:0]), 64'h0);
    for (int k = 0; k < 3; k++) begin
      next();
      set_rd(0, 0);
      @(negedge clk);
      chk("x0 read", 64'(rd_data[DW-1:0]), 64'h0);
      chk("x0 busy", 64'(busy_vec[0]), 64'h0);
    end
    next();

    // 4. write collision
    set_wr(0, 7, 32'h11, 0);
    set_wr(1, 7, 32'h22, 0);
    set_rd(1, 7);
    @(negedge clk);
    chk("collision bypass", 64'(rd_data[DW +: DW]), 64'h22);
    next();
    set_rd(1, 7);
    @(negedge clk);
    chk("collision stored", 64'(rd_data[DW +: DW]), 64'h22);
    next();

    // 5. scoreboard
    iss_en = 1; iss_addr = 3;
    next();
    set_rd(1, 3);
    @(negedge clk);
    chk("issue x3", 64'(busy_vec[3]), 64'h1);
    chk("issue x3 rd_busy", 64'(rd_busy[1]), 64'h1);
    set_wr(1, 3, 32'hCAFE, 1);
    @(negedge clk);
    chk("release bypass", 64'(rd_busy[1]), 64'h0);
    next();
    @(negedge clk);
    chk("released x3", 64'(busy_vec[3]), 64'h0);
    iss_en = 1; iss_addr = 3;
    next();
    iss_en = 1; iss_addr = 3;
    set_wr(0, 3, 32'hBEEF, 1);
    @(negedge clk);
    chk("iss+rel rd_busy", 64'(rd_busy[1]), 64'h1);
    next();
    @(negedge clk);
    chk("iss beats rel", 64'(busy_vec[3]), 64'h1);

    // 6. flush
    iss_en = 1; iss_addr = 9;
    next();
    @(negedge clk);
    chk("x3,x9 busy", 64'(busy_vec), 64'h208);
    flush = 1; iss_en = 1; iss_addr = 4;
    next();
    set_rd(0, 5); set_rd(1, 7);
    @(negedge clk);
    chk("flush busy_vec", 64'(busy_vec), 64'h0);
    chk("flush keeps x5", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
    chk("flush keeps x7", 64'(rd_data[DW +: DW]), 64'h22);
    next();

    // randomized traffic, checked every cycle by the compare process
    for (int k = 0; k < 3000; k++) begin
      rand_inputs();
      @(posedge clk);
      #1;
    end
    idle();
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file. It is the next generation of the single-write, two-read pipeline regfile.
- N read ports, M write ports, with internal write-to-read bypass, so decode no longer supplies forward selects.
- A per-register scoreboard (busy bits) with issue-set, writeback-clear and flush, used by the decode stage for hazard stalls.
- Sits between decode (read, issue) and writeback (write, release).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers; power of two, >= 2
NUM_RD, 2, number of read ports, >= 1
NUM_WR, 1, number of write ports, >= 1
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary
AW (derived, localparam), $clog2(NUM_REGS), address width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset
rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW]
rd_data  out  NUM_RD*DATA_W  read data, packed the same way
rd_busy  out  NUM_RD  1 = the addressed register has an outstanding producer
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*DATA_W  write data
wr_release  in  NUM_WR  with wr_en, also clear the busy bit of wr_addr
iss_en  in  1  mark iss_addr busy (instruction issued with a destination)
iss_addr  in  AW  destination register being allocated
flush  in  1  clear all busy bits (pipeline squash); storage untouched
busy_vec  out  NUM_REGS  raw scoreboard state, bit r = register r

Behaviour:
Reset
- Clock is clk. Reset rst_n is synchronous, active-low.
- On a clk edge with rst_n = 0: all storage is set to 0 and all busy bits are set to 0.
- While rst_n = 0: rd_data = 0, rd_busy = 0 and busy_vec = 0 on all ports, regardless of state.

Writes
- Take effect on the clk edge when wr_en[j] = 1.
- If ZERO_REG = 1, writes to address 0 are dropped.
- Same-address collision: the highest-index write port wins.

Reads (default build, combinational, 0-cycle latency)
- rd_data[i] = value of storage[rd_addr[i]].
- Bypass: if any wr_en[j] with wr_addr[j] == rd_addr[i] is active this cycle, return that wr_data instead. Highest-index matching port wins.
- Register 0 with ZERO_REG = 1 always reads 0; no bypass.

Scoreboard
- Next busy[r], evaluated in order:
  1. flush: 0.
  2. Else iss_en && iss_addr == r: 1. Set beats release in the same cycle, because a newer producer replaces the old one.
  3. Else any (wr_en[j] && wr_release[j] && wr_addr[j] == r): 0.
  4. Else hold.
- flush with iss_en in the same cycle: flush wins; the register is not busy.
- ZERO_REG = 1: busy[0] is always 0 and iss to register 0 is ignored.
- rd_busy[i]: busy[rd_addr[i]] masked with same-cycle release bypass.
  - Reads 0 if a releasing write to that address is active this cycle, so decode sees bypassed data as ready.
  - Release bypass is suppressed by a same-cycle iss_en to that address, so rd_busy reads 1.
- busy_vec is the raw registered state, with no bypass.

Widths
- Addresses >= NUM_REGS cannot occur, since NUM_REGS is a power of two.
- wr_release without wr_en is ignored.

Optional Feature:
Macro REGFILE_MP_RDREG_EN.
- Defined: rd_data and rd_busy are registered, giving 1-cycle latency.
  - Outputs are sampled from the bypassed combinational values at the edge that addresses are presented.
  - The output registers reset to 0.
- Undefined: the combinational path described above.

Test Plan:
1. Reset: rst_n = 0 for 2 cycles after random writes -> all rd_data = 0, busy_vec = 0; after release, reading regs 1..31 gives 0.
2. Write/read with bypass: write x5 = 0xDEADBEEF; the same cycle, read port 0 at x5 -> 0xDEADBEEF at once (combinational). Next cycle, with no write, still 0xDEADBEEF.
3. Zero register: write x0 = 0x1234 and iss_addr = 0 -> rd_data = 0 and busy_vec[0] = 0 in all later cycles.
4. Write collision (NUM_WR = 2): both ports write x7, port0 = 0x11 and port1 = 0x22 -> bypass read returns 0x22, and stored x7 = 0x22.
5. Scoreboard:
   - Issue x3 -> busy_vec[3] = 1 the next cycle.
   - Write x3 with release -> rd_busy = 0 in the write cycle and busy_vec[3] = 0 after the edge.
   - Simultaneous iss x3 and release x3 -> busy_vec[3] stays 1.
6. Flush: with x3 and x9 busy, flush = 1 and iss x4 in the same cycle -> busy_vec = 0 after the edge. Storage values are unchanged.
